// File: rtl/icache_tag_assoc.sv
// N-way set-associative icache tag store: registered lookup with one-hot hit,
// victim selection (first invalid, else tree-PLRU), fills and set invalidation.

module icache_tag_way_cmp #(
  parameter int TAG_W = 20
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] ref_tag,
  output logic             match
);
  assign match = valid && (tag == ref_tag);
endmodule

module icache_tag_assoc #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 128,
  parameter int LINE_BYTES = 32,
  parameter int WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              hit,
  output logic [WAYS-1:0]   hit_way,
  output logic [WAYS-1:0]   victim_way,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [WAYS-1:0]   fill_way,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]     state;
  logic [IDX_W:0] init_cnt;

  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
  logic [2:0]                  plru_q  [SETS];

  logic                        rsp_pend;
  logic [IDX_W-1:0]            r_idx;
  logic [TAG_W-1:0]            r_tag;
  logic [WAYS-1:0]             r_valid;
  logic [WAYS-1:0][TAG_W-1:0]  r_tags;
  logic [2:0]                  r_plru;

  logic [IDX_W-1:0] req_idx, fill_idx, inv_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;

  assign req_idx  = req_addr[IDX_W+OFF_W-1:OFF_W];
  assign fill_idx = fill_addr[IDX_W+OFF_W-1:OFF_W];
  assign inv_idx  = inv_addr[IDX_W+OFF_W-1:OFF_W];
  assign req_tag  = req_addr[ADDR_W-1:IDX_W+OFF_W];
  assign fill_tag = fill_addr[ADDR_W-1:IDX_W+OFF_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[OFF_W-1:0], fill_addr[OFF_W-1:0],
                              inv_addr[OFF_W-1:0], inv_addr[ADDR_W-1:IDX_W+OFF_W]};

  assign ready = (state == S_RUN);

  // PLRU bit semantics: 2-way bit0=1 means way1 is LRU; 4-way bit0 picks the
  // LRU half (0=ways 0/1), bit1/bit2 pick the LRU way within each half.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n = p;
    if (WAYS == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end else if (WAYS == 2) begin
      n[0] = ~w[0];
    end
    return n;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    if (WAYS == 4)      return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    else if (WAYS == 2) return {1'b0, p[0]};
    else                return 2'd0;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [WAYS-1:0] oh);
    logic [1:0] i;
    i = '0;
    for (int k = 0; k < WAYS; k++)
      if (oh[k]) i = 2'(k);
    return i;
  endfunction

  logic [WAYS-1:0] match, hit_oh, vict_oh;
  logic [1:0]      hit_idx, vict_idx;
  logic            found, inv_found;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_tag_way_cmp #(.TAG_W(TAG_W)) u_cmp (
      .valid   (r_valid[w]),
      .tag     (r_tags[w]),
      .ref_tag (r_tag),
      .match   (match[w])
    );
  end

  always_comb begin
    hit_oh    = '0;
    hit_idx   = '0;
    found     = 1'b0;
    vict_idx  = plru_victim(r_plru);
    inv_found = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (match[k] && !found) begin
        hit_oh[k] = 1'b1;
        hit_idx   = 2'(k);
        found     = 1'b1;
      end
      if (!r_valid[k] && !inv_found) begin
        vict_idx  = 2'(k);
        inv_found = 1'b1;
      end
    end
    vict_oh = WAYS'(1) << vict_idx;
  end

  assign rsp_valid  = rsp_pend;
  assign hit        = rsp_pend && found;
  assign hit_way    = rsp_pend ? hit_oh  : '0;
  assign victim_way = rsp_pend ? vict_oh : '0;

  logic       hit_upd, fill_do;
  logic [2:0] plru_h, plru_f;

  assign hit_upd = rsp_pend && found;
  // Same-set invalidate beats the fill; a malformed way select writes nothing.
  assign fill_do = ready && fill_en && $onehot(fill_way) && !(inv_en && (inv_idx == fill_idx));

  // Hit and fill touching the same set chain so the fill lands as MRU last.
  always_comb begin
    plru_h = plru_touch(plru_q[r_idx], hit_idx);
    plru_f = plru_touch((hit_upd && (fill_idx == r_idx)) ? plru_h : plru_q[fill_idx],
                        oh2idx(fill_way));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
      rsp_pend <= 1'b0;
    end else if (state == S_INIT) begin
      rsp_pend <= 1'b0;
      if (init_cnt == (IDX_W+1)'(SETS)) begin
        state <= S_RUN;
      end else begin
        valid_q[init_cnt[IDX_W-1:0]] <= '0;
        plru_q[init_cnt[IDX_W-1:0]]  <= '0;
        init_cnt                     <= init_cnt + 1'b1;
      end
    end else begin
      rsp_pend <= req_valid;
      if (hit_upd) plru_q[r_idx] <= plru_h;
      if (fill_do) begin
        valid_q[fill_idx] <= valid_q[fill_idx] | fill_way;
        plru_q[fill_idx]  <= plru_f;
        for (int k = 0; k < WAYS; k++)
          if (fill_way[k]) tag_q[fill_idx][k] <= fill_tag;
      end
      if (inv_en) valid_q[inv_idx] <= '0;
    end
  end

  // Set snapshot taken before this cycle's writes land (read-before-write).
  always_ff @(posedge clk) begin
    if (ready && req_valid) begin
      r_idx   <= req_idx;
      r_tag   <= req_tag;
      r_valid <= valid_q[req_idx];
      r_tags  <= tag_q[req_idx];
      r_plru  <= plru_q[req_idx];
    end
  end
endmodule

// File: tb/tb_icache_tag_assoc.sv
// Directed bench for icache_tag_assoc (defaults: 2-way, 128 sets, 32B lines).
module tb_icache_tag_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        hit;
  logic [1:0]  hit_way;
  logic [1:0]  victim_way;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [1:0]  fill_way;
  logic        inv_en;
  logic [31:0] inv_addr;

  always #5 clk = ~clk;

  icache_tag_assoc dut (
    .clk(clk), .rst(rst), .ready(ready),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_way(fill_way),
    .inv_en(inv_en), .inv_addr(inv_addr)
  );

  typedef struct packed {
    logic       hit;
    logic [1:0] hw;
    logic [1:0] vw;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;

  function automatic logic [31:0] mk(input logic [19:0] tag, input logic [6:0] idx);
    return {tag, idx, 5'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  // Scoreboard: every rsp_valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        n_tests += 3;
        assert (hit === mon_e.hit) else begin
          n_fail++; $error("FAIL rsp_hit observed=%0b expected=%0b", hit, mon_e.hit);
        end
        assert (hit_way === mon_e.hw) else begin
          n_fail++; $error("FAIL rsp_hit_way observed=%0b expected=%0b", hit_way, mon_e.hw);
        end
        assert (victim_way === mon_e.vw) else begin
          n_fail++; $error("FAIL rsp_victim_way observed=%0b expected=%0b", victim_way, mon_e.vw);
        end
      end
    end
  end

  task automatic step(input logic rv, input logic [31:0] ra,
                      input logic fv, input logic [31:0] fa, input logic [1:0] fw,
                      input logic iv, input logic [31:0] ia,
                      input logic eh, input logic [1:0] ehw, input logic [1:0] evw);
    exp_t e;
    req_valid = rv; req_addr = ra;
    fill_en = fv; fill_addr = fa; fill_way = fw;
    inv_en = iv; inv_addr = ia;
    if (rv) begin
      e.hit = eh; e.hw = ehw; e.vw = evw;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; fill_en = 1'b0; inv_en = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic eh, input logic [1:0] ehw, input logic [1:0] evw);
    step(1'b1, a, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, eh, ehw, evw);
  endtask

  task automatic fill(input logic [31:0] a, input logic [1:0] w);
    step(1'b0, 32'h0, 1'b1, a, w, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic wait_ready(input string nm);
    int c;
    c = 0;
    while (!ready && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk(nm, c, 129);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; fill_en = 1'b0; fill_addr = '0;
    fill_way = '0; inv_en = 1'b0; inv_addr = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_ready", ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_way", hit_way, 0);
    chk("rst_victim_way", victim_way, 0);

    // INIT: requests and fills issued now must be ignored.
    rst = 1'b0;
    n = 0;
    while (!ready && n < 300) begin
      req_valid = (n == 5);   req_addr  = mk(20'h1, 7'd2);
      fill_en   = (n == 100); fill_addr = mk(20'h77, 7'd3); fill_way = 2'b01;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0; fill_en = 1'b0;
    chk("init_len", n, 129);

    // Fill then hit in set 2.
    fill(32'h0000_1040, 2'b01);
    req(32'h0000_1044, 1'b1, 2'b01, 2'b10);

    // PLRU: after A hit, B (way1) is LRU.
    fill(mk(20'h2, 7'd2), 2'b10);
    req(mk(20'h1, 7'd2), 1'b1, 2'b01, 2'b01);
    idle();
    req(mk(20'h3, 7'd2), 1'b0, 2'b00, 2'b10);

    // Invalidate wins over a same-set fill.
    step(1'b0, 32'h0, 1'b1, mk(20'h5, 7'd2), 2'b01, 1'b1, mk(20'h0, 7'd2), 1'b0, 2'b00, 2'b00);
    req(mk(20'h1, 7'd2), 1'b0, 2'b00, 2'b01);

    // Invalidate and fill to different sets both happen.
    step(1'b0, 32'h0, 1'b1, mk(20'h9, 7'd7), 2'b10, 1'b1, mk(20'h0, 7'd2), 1'b0, 2'b00, 2'b00);
    req(mk(20'h9, 7'd7), 1'b1, 2'b10, 2'b01);

    // Read-before-write, then back-to-back visibility.
    step(1'b1, mk(20'hAB, 7'd5), 1'b1, mk(20'hAB, 7'd5), 2'b01, 1'b0, 32'h0, 1'b0, 2'b00, 2'b01);
    req(mk(20'hAB, 7'd5), 1'b1, 2'b01, 2'b10);

    // Duplicate tags in both ways: lowest way reported.
    fill(mk(20'h4, 7'd9), 2'b01);
    fill(mk(20'h4, 7'd9), 2'b10);
    req(mk(20'h4, 7'd9), 1'b1, 2'b01, 2'b01);

    // Non-one-hot fill_way writes nothing.
    fill(mk(20'h6, 7'd11), 2'b11);
    fill(mk(20'h6, 7'd11), 2'b00);
    req(mk(20'h6, 7'd11), 1'b0, 2'b00, 2'b01);

    // Hit update and fill in the same cycle: fill is the final MRU.
    fill(mk(20'h1, 7'd12), 2'b01);
    fill(mk(20'h2, 7'd12), 2'b10);
    req(mk(20'h1, 7'd12), 1'b1, 2'b01, 2'b01);
    fill(mk(20'h2, 7'd12), 2'b10);
    req(mk(20'h3, 7'd12), 1'b0, 2'b00, 2'b01);

    // Fill issued during INIT left set 3 untouched.
    req(mk(20'h77, 7'd3), 1'b0, 2'b00, 2'b01);

    // Reset with a request in flight drops it; reset mid-INIT restarts.
    rst = 1'b1; req_valid = 1'b1; req_addr = mk(20'h1, 7'd12);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    repeat (60) begin @(posedge clk); #1; end
    chk("mid_init_ready", ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("reinit_len");
    req(mk(20'h9, 7'd7), 1'b0, 2'b00, 2'b01);

    repeat (3) idle();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
